// File: rtl/wb_queue_pkg.sv
// Shared types for the write-back queue: register address/data widths and the queued entry.
package wb_queue_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [REG_DATA_W-1:0] data;
  } wb_entry_t;

  // Register 0 is hard-wired: writes to it are dropped and lookups never hit.
  function automatic logic is_reg_zero(input logic [REG_ADDR_W-1:0] addr);
    return (addr == REG_ADDR_W'(0));
  endfunction

endpackage

// File: rtl/wb_match.sv
// Youngest-match search of the pending-write queue for one decode read port.
// Data selection exists only when WB_QUEUE_BYPASS_EN is defined.
module wb_match
  import wb_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH),
  parameter int CNT_W = PTR_W + 1
) (
  input  logic [REG_ADDR_W-1:0] addr_tab [DEPTH],
`ifdef WB_QUEUE_BYPASS_EN
  input  logic [REG_DATA_W-1:0] data_tab [DEPTH],
  output logic [REG_DATA_W-1:0] fwd_data,
`endif
  input  logic [PTR_W-1:0]      rd_ptr,
  input  logic [CNT_W-1:0]      count,
  input  logic [REG_ADDR_W-1:0] raddr,
  output logic                  busy
);

  logic [PTR_W-1:0] idx_s;
  logic             busy_s;
`ifdef WB_QUEUE_BYPASS_EN
  logic [REG_DATA_W-1:0] data_s;
`endif

  // Walk entries oldest to youngest so the last hit is the youngest.
  always_comb begin
    busy_s = 1'b0;
    idx_s  = rd_ptr;
`ifdef WB_QUEUE_BYPASS_EN
    data_s = REG_DATA_W'(0);
`endif
    for (int i = 0; i < DEPTH; i++) begin
      idx_s = rd_ptr + PTR_W'(i);
      if ((CNT_W'(i) < count) && !is_reg_zero(raddr) && (addr_tab[idx_s] == raddr)) begin
        busy_s = 1'b1;
`ifdef WB_QUEUE_BYPASS_EN
        data_s = data_tab[idx_s];
`endif
      end else begin
        busy_s = busy_s;
      end
    end
  end

  assign busy = busy_s;
`ifdef WB_QUEUE_BYPASS_EN
  assign fwd_data = data_s;
`endif

endmodule

// File: rtl/wb_queue.sv
// In-order register write-back FIFO with decode hazard lookup.
// Optional forwarding data path enabled by WB_QUEUE_BYPASS_EN.
module wb_queue
  import wb_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [REG_ADDR_W-1:0]   in_addr,
  input  logic [REG_DATA_W-1:0]   in_data,
  input  logic                    rf_stall,
  output logic                    rf_w,
  output logic [REG_ADDR_W-1:0]   waddr,
  output logic [REG_DATA_W-1:0]   wdata,
  input  logic [REG_ADDR_W-1:0]   raddr1,
  input  logic [REG_ADDR_W-1:0]   raddr2,
  output logic                    busy1,
  output logic                    busy2,
  output logic [REG_DATA_W-1:0]   fwd_data1,
  output logic [REG_DATA_W-1:0]   fwd_data2,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  wb_entry_t             mem_r [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_r;
  logic [PTR_W-1:0]      rd_ptr_r;
  logic [CNT_W-1:0]      count_r;
  logic                  push_s;
  logic                  pop_s;
  logic [REG_ADDR_W-1:0] addr_tab_s [DEPTH];
`ifdef WB_QUEUE_BYPASS_EN
  logic [REG_DATA_W-1:0] data_tab_s [DEPTH];
`endif

  // A full queue refuses input even when the head pops this same cycle.
  assign in_ready = (count_r != CNT_W'(DEPTH));
  assign push_s   = in_valid && in_ready && !is_reg_zero(in_addr);
  assign rf_w     = (count_r != CNT_W'(0));
  assign pop_s    = rf_w && !rf_stall;
  assign waddr    = rf_w ? mem_r[rd_ptr_r].addr : REG_ADDR_W'(0);
  assign wdata    = rf_w ? mem_r[rd_ptr_r].data : REG_DATA_W'(0);
  assign count    = count_r;

  // Pointer and occupancy state; reset drops every pending write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= PTR_W'(0);
      rd_ptr_r <= PTR_W'(0);
      count_r  <= CNT_W'(0);
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage is not reset; occupancy alone decides validity.
  always_ff @(posedge clk) begin
    if (push_s) mem_r[wr_ptr_r] <= '{addr: in_addr, data: in_data};
  end

  // Split storage into per-field tables for the lookup units.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      addr_tab_s[i] = mem_r[i].addr;
`ifdef WB_QUEUE_BYPASS_EN
      data_tab_s[i] = mem_r[i].data;
`endif
    end
  end

  wb_match #(.DEPTH(DEPTH)) u_match1 (
    .addr_tab (addr_tab_s),
`ifdef WB_QUEUE_BYPASS_EN
    .data_tab (data_tab_s),
    .fwd_data (fwd_data1),
`endif
    .rd_ptr   (rd_ptr_r),
    .count    (count_r),
    .raddr    (raddr1),
    .busy     (busy1)
  );

  wb_match #(.DEPTH(DEPTH)) u_match2 (
    .addr_tab (addr_tab_s),
`ifdef WB_QUEUE_BYPASS_EN
    .data_tab (data_tab_s),
    .fwd_data (fwd_data2),
`endif
    .rd_ptr   (rd_ptr_r),
    .count    (count_r),
    .raddr    (raddr2),
    .busy     (busy2)
  );

`ifndef WB_QUEUE_BYPASS_EN
  assign fwd_data1 = REG_DATA_W'(0);
  assign fwd_data2 = REG_DATA_W'(0);
`endif

endmodule

// File: tb/tb_wb_queue.sv
// Self-checking bench for wb_queue against a queue-based reference model.
module tb_wb_queue;

  localparam int DEPTH = 4;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  in_addr = 5'd0;
  logic [31:0] in_data = 32'd0;
  logic        rf_stall = 1'b0;
  logic        rf_w;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [4:0]  raddr1 = 5'd0;
  logic [4:0]  raddr2 = 5'd0;
  logic        busy1, busy2;
  logic [31:0] fwd_data1, fwd_data2;
  logic [2:0]  count;

  int errors = 0;
  int checks = 0;
  ent_t q[$];

  always #5 clk = ~clk;

  wb_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_addr(in_addr), .in_data(in_data), .rf_stall(rf_stall), .rf_w(rf_w),
    .waddr(waddr), .wdata(wdata), .raddr1(raddr1), .raddr2(raddr2),
    .busy1(busy1), .busy2(busy2), .fwd_data1(fwd_data1), .fwd_data2(fwd_data2),
    .count(count)
  );

  function automatic logic m_busy(input logic [4:0] r);
    if (r == 5'd0) return 1'b0;
    foreach (q[i]) if (q[i].a == r) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] m_fwd(input logic [4:0] r);
    logic [31:0] v;
    v = 32'd0;
`ifdef WB_QUEUE_BYPASS_EN
    if (r != 5'd0) foreach (q[i]) if (q[i].a == r) v = q[i].d;
`endif
    return v;
  endfunction

  function automatic logic [4:0] m_waddr();
    return (q.size() != 0) ? q[0].a : 5'd0;
  endfunction

  function automatic logic [31:0] m_wdata();
    return (q.size() != 0) ? q[0].d : 32'd0;
  endfunction

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic tick();
    bit   acc, pop;
    ent_t e;
    acc = in_valid && (q.size() != DEPTH) && !rst;
    pop = (q.size() != 0) && !rf_stall && !rst;
    e.a = in_addr;
    e.d = in_data;
    @(posedge clk);
    if (pop) void'(q.pop_front());
    if (acc && e.a != 5'd0) q.push_back(e);
    #1;
  endtask

  task automatic test_reset();
    #2;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    checks++; if (rf_w !== 1'b0) begin errors++; $display("FAIL reset_rf_w: got %b want 0", rf_w); end
    checks++; if (waddr !== 5'd0 || wdata !== 32'd0) begin errors++; $display("FAIL reset_wport: got %0d/%h want 0/0", waddr, wdata); end
    checks++; if (busy1 !== 1'b0 || busy2 !== 1'b0 || fwd_data1 !== 32'd0 || fwd_data2 !== 32'd0) begin
      errors++; $display("FAIL reset_lookup: got %b %b %h %h want zeros", busy1, busy2, fwd_data1, fwd_data2);
    end
    rst = 1'b0;
    q.delete();
    tick();
  endtask

  task automatic test_single();
    in_valid = 1'b1; in_addr = 5'd5; in_data = 32'h1234;
    tick();
    in_valid = 1'b0;
    #1;
    checks++; if (rf_w !== 1'b1) begin errors++; $display("FAIL single_rf_w: got %b want 1", rf_w); end
    checks++; if (waddr !== 5'd5 || wdata !== 32'h1234) begin errors++; $display("FAIL single_head: got %0d/%h want 5/1234", waddr, wdata); end
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL single_count: got %0d want 1", count); end
    tick();
    checks++; if (count !== 3'd0 || rf_w !== 1'b0) begin errors++; $display("FAIL single_drain: got count=%0d rf_w=%b want 0/0", count, rf_w); end
  endtask

  task automatic test_stall_fill();
    rf_stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_addr = 5'(3 + i); in_data = $urandom;
      tick();
    end
    in_valid = 1'b1; in_addr = 5'd9; in_data = 32'hDEAD;
    #1;
    checks++; if (count !== 3'd4 || in_ready !== 1'b0) begin errors++; $display("FAIL fill_full: got count=%0d in_ready=%b want 4/0", count, in_ready); end
    checks++; if (rf_w !== 1'b1 || waddr !== 5'd3) begin errors++; $display("FAIL fill_head: got rf_w=%b waddr=%0d want 1/3", rf_w, waddr); end
    tick();
    checks++; if (waddr !== 5'd3) begin errors++; $display("FAIL fill_hold: got %0d want 3", waddr); end
    rf_stall = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_pop_ready: got %b want 0", in_ready); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (waddr !== 5'(3 + i) || wdata !== m_wdata() || rf_w !== 1'b1) begin
        errors++; $display("FAIL drain_order: got %b/%0d/%h want 1/%0d/%h", rf_w, waddr, wdata, 3 + i, m_wdata());
      end
      tick();
      in_valid = 1'b0;
      #1;
    end
    checks++; if (count !== 3'd0 || rf_w !== 1'b0) begin errors++; $display("FAIL drain_empty: got count=%0d rf_w=%b want 0/0", count, rf_w); end
  endtask

  task automatic test_zero_addr();
    in_valid = 1'b1; in_addr = 5'd0; in_data = 32'hFFFF;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL zero_ready: got %b want 1", in_ready); end
    tick();
    in_valid = 1'b0;
    #1;
    checks++; if (count !== 3'd0 || rf_w !== 1'b0) begin errors++; $display("FAIL zero_enq: got count=%0d rf_w=%b want 0/0", count, rf_w); end
  endtask

  task automatic test_hazard();
    rf_stall = 1'b1;
    in_valid = 1'b1; in_addr = 5'd7; in_data = 32'hA;
    tick();
    in_addr = 5'd7; in_data = 32'hB;
    tick();
    in_addr = 5'd9; in_data = 32'h99;
    raddr1 = 5'd7; raddr2 = 5'd0;
    #1;
    checks++; if (busy1 !== 1'b1 || fwd_data1 !== m_fwd(5'd7)) begin errors++; $display("FAIL hazard_port1: got %b/%h want 1/%h", busy1, fwd_data1, m_fwd(5'd7)); end
    checks++; if (busy2 !== 1'b0 || fwd_data2 !== 32'd0) begin errors++; $display("FAIL hazard_r0: got %b/%h want 0/0", busy2, fwd_data2); end
    raddr2 = 5'd9;
    #1;
    checks++; if (busy2 !== 1'b0 || fwd_data2 !== 32'd0) begin errors++; $display("FAIL hazard_inflight: got %b/%h want 0/0", busy2, fwd_data2); end
    in_valid = 1'b0;
    raddr1 = 5'd0; raddr2 = 5'd0;
    rf_stall = 1'b0;
    tick(); tick();
  endtask

  task automatic test_reset_mid();
    rf_stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_addr = 5'(20 + i); in_data = $urandom;
      tick();
    end
    in_addr = 5'd11;
    #2;
    rst = 1'b1;
    #1;
    checks++; if (count !== 3'd0 || rf_w !== 1'b0 || in_ready !== 1'b1 || waddr !== 5'd0) begin
      errors++; $display("FAIL rst_async: got count=%0d rf_w=%b in_ready=%b waddr=%0d want 0/0/1/0", count, rf_w, in_ready, waddr);
    end
    q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    in_valid = 1'b0;
    #1;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL rst_handshake: got %0d want 0", count); end
    rf_stall = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    rf_stall = 1'b0;
    for (int k = 1; k < 32; k++) begin
      in_valid = 1'b1; in_addr = 5'(k); in_data = $urandom;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready: got %b want 1 at %0d", in_ready, k); end
      tick();
      checks++; if (count !== 3'd1 || waddr !== 5'(k) || wdata !== m_wdata()) begin
        errors++; $display("FAIL b2b_write: got count=%0d %0d/%h want 1 %0d/%h", count, waddr, wdata, k, m_wdata());
      end
    end
    in_valid = 1'b0;
    tick();
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL b2b_drain: got %0d want 0", count); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_addr  = 5'($urandom_range(0, 7));
      in_data  = $urandom;
      rf_stall = ($urandom_range(0, 2) == 0);
      raddr1   = 5'($urandom_range(0, 7));
      raddr2   = 5'($urandom_range(0, 7));
      #1;
      checks++; if (count !== 3'(q.size()) || in_ready !== (q.size() != DEPTH) || rf_w !== (q.size() != 0)) begin
        errors++; $display("FAIL rnd_state: got count=%0d ready=%b rf_w=%b want %0d", count, in_ready, rf_w, q.size());
      end
      checks++; if (waddr !== m_waddr() || wdata !== m_wdata()) begin
        errors++; $display("FAIL rnd_head: got %0d/%h want %0d/%h", waddr, wdata, m_waddr(), m_wdata());
      end
      checks++; if (busy1 !== m_busy(raddr1) || fwd_data1 !== m_fwd(raddr1)) begin
        errors++; $display("FAIL rnd_port1: got %b/%h want %b/%h", busy1, fwd_data1, m_busy(raddr1), m_fwd(raddr1));
      end
      checks++; if (busy2 !== m_busy(raddr2) || fwd_data2 !== m_fwd(raddr2)) begin
        errors++; $display("FAIL rnd_port2: got %b/%h want %b/%h", busy2, fwd_data2, m_busy(raddr2), m_fwd(raddr2));
      end
      tick();
    end
    in_valid = 1'b0;
    rf_stall = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_stall_fill();
    test_zero_addr();
    test_hazard();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
